rr_arbiter_8: RTL and testbench

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

---
 rtl/rr_arbiter_8.sv | 73 +++++++
 tb/tb_rr_arbiter_8.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter. A grant is held until done, withdrawal or the
// hold limit, and at least one idle cycle separates consecutive grants.
module rr_arbiter_8 #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

  state_t     state;
  logic [2:0] ptr;
  logic [3:0] hold_cnt;
  logic [2:0] pick;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    pick = ptr;
    for (int off = 7; off >= 0; off--) begin
      if (req[ptr + 3'(off)]) pick = ptr + 3'(off);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      hold_cnt  <= 4'd0;
      gnt       <= 8'd0;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (req != 8'd0) begin
            state     <= BUSY;
            gnt       <= 8'd1 << pick;
            gnt_idx   <= pick;
            gnt_valid <= 1'b1;
            hold_cnt  <= 4'd0;
          end
        end
        BUSY: begin
          // done/withdrawal is checked first so it suppresses the timeout pulse.
          if (done || !req[gnt_idx] || hold_cnt == HOLD_LAST) begin
            state     <= IDLE;
            ptr       <= gnt_idx + 3'd1;
            gnt       <= 8'd0;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            hold_cnt  <= 4'd0;
            timeout   <= !(done || !req[gnt_idx]);
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8: a cycle-level reference model checked every
// cycle, plus hand-computed expectations at the key points of each scenario.
module tb_rr_arbiter_8;

  localparam int HOLD_MAX = 8;

  logic       clk = 1'b0;
  logic       nrst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  rr_arbiter_8 #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .nrst(nrst), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference model: who holds the grant, for how many cycles, and where the scan starts.
  bit m_busy;
  int m_holder;
  int m_held;
  int m_ptr;
  bit m_to;

  always @(negedge nrst) begin
    m_busy = 0; m_holder = 0; m_held = 0; m_ptr = 0; m_to = 0;
  end

  always @(posedge clk) begin
    if (nrst) begin
      m_to = 0;
      if (!m_busy) begin
        if (req != 8'd0) begin
          for (int k = 7; k >= 0; k--)
            if (req[(m_ptr + k) % 8]) m_holder = (m_ptr + k) % 8;
          m_busy = 1;
          m_held = 1;
        end
      end else if (done || !req[m_holder]) begin
        m_busy = 0;
        m_ptr  = (m_holder + 1) % 8;
      end else if (m_held == HOLD_MAX) begin
        m_busy = 0;
        m_ptr  = (m_holder + 1) % 8;
        m_to   = 1;
      end else begin
        m_held++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("gnt",       32'(gnt),       m_busy ? 32'(8'd1 << m_holder) : 32'd0);
    chk("gnt_idx",   32'(gnt_idx),   m_busy ? 32'(m_holder) : 32'd0);
    chk("gnt_valid", 32'(gnt_valid), 32'(m_busy));
    chk("timeout",   32'(timeout),   32'(m_to));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    cyc(2);
    nrst = 1'b1;
  endtask

  int held;

  initial begin
    req = 8'd0; done = 1'b0; nrst = 1'b1;
    #1 nrst = 1'b0;
    cyc(2);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valid", 32'(gnt_valid), 32'd0);
    nrst = 1'b1;

    // Single request, then release with done.
    req = 8'b0000_0100;
    cyc(1);
    chk("single_gnt", 32'(gnt), 32'h04);
    chk("single_idx", 32'(gnt_idx), 32'd2);
    chk("single_valid", 32'(gnt_valid), 32'd1);
    done = 1'b1;
    cyc(1);
    chk("single_rel", 32'(gnt), 32'd0);
    chk("single_ptr", 32'(m_ptr), 32'd3);
    done = 1'b0; req = 8'd0;
    cyc(1);

    // Rotation from ptr=0 with all requests held.
    do_reset();
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      cyc(1);
      chk("rot_idx", 32'(gnt_idx), 32'(i % 8));
      chk("rot_valid", 32'(gnt_valid), 32'd1);
      done = 1'b1;
      cyc(1);
      chk("rot_gap", 32'(gnt_valid), 32'd0);
      done = 1'b0;
    end
    req = 8'd0;
    cyc(1);

    // Wrap-around: grant 5 so ptr=6, then 0 must win over 1.
    req = 8'h20;
    cyc(1);
    chk("wrap_pre", 32'(gnt_idx), 32'd5);
    done = 1'b1;
    cyc(1);
    done = 1'b0; req = 8'b0000_0011;
    cyc(1);
    chk("wrap_idx", 32'(gnt_idx), 32'd0);
    done = 1'b1;
    cyc(1);
    chk("wrap_ptr", 32'(m_ptr), 32'd1);
    done = 1'b0; req = 8'd0;
    cyc(1);

    // Hold limit: grant lasts exactly HOLD_MAX cycles, then timeout for one cycle.
    req = 8'h01;
    held = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (gnt_valid) held++;
      else if (held != 0) break;
    end
    chk("to_held", 32'(held), 32'(HOLD_MAX));
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_gnt", 32'(gnt), 32'd0);
    cyc(1);
    chk("to_regrant", 32'(gnt), 32'h01);
    chk("to_clear", 32'(timeout), 32'd0);

    // done coinciding with the last allowed cycle suppresses timeout.
    cyc(HOLD_MAX - 1);
    done = 1'b1;
    cyc(1);
    chk("sim_valid", 32'(gnt_valid), 32'd0);
    chk("sim_to", 32'(timeout), 32'd0);
    done = 1'b0; req = 8'd0;
    cyc(1);

    // Asynchronous reset in the middle of a grant.
    req = 8'h08;
    cyc(1);
    chk("ar_pre", 32'(gnt_idx), 32'd3);
    #2 nrst = 1'b0;
    #1;
    chk("ar_gnt", 32'(gnt), 32'd0);
    chk("ar_valid", 32'(gnt_valid), 32'd0);
    chk("ar_to", 32'(timeout), 32'd0);
    cyc(1);
    nrst = 1'b1; req = 8'h80;
    cyc(1);
    chk("ar_idx", 32'(gnt_idx), 32'd7);
    done = 1'b1;
    cyc(1);
    chk("ar_ptr", 32'(m_ptr), 32'd0);
    done = 1'b0; req = 8'd0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
